execute_stage: RTL and testbench

Execute stage of the five-stage RV32I pipelined core. It consumes the ID/EX pipeline register outputs: controls, operands, immediate, register addresses and PCs. It resolves operand forwarding, performs the ALU operation and computes the branch target and taken decision. Results are registered into the EX/MEM pipeline register for the memory stage.

---
 rtl/execute_stage_pkg.sv | 42 ++++
 rtl/execute_stage_alu.sv | 31 +++
 rtl/execute_stage.sv | 85 ++++++++
 tb/tb_execute_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared constants and the EX/MEM bundle
// for the RV32I execute stage.
package execute_stage_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        result_src;
    logic [4:0]  rd;
    logic [31:0] pc_plus4;
    logic [31:0] write_data;
    logic [31:0] alu_result;
  } ex_mem_t;

  // Select 2'b11 falls back to the register file value.
  function automatic logic [31:0] fwd_mux(
    input logic [1:0]  sel,
    input logic [31:0] rf,
    input logic [31:0] w,
    input logic [31:0] m
  );
    logic [31:0] r;
    r = rf;
    case (sel)
      FWD_W:   r = w;
      FWD_M:   r = m;
      default: r = rf;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit ALU for the execute stage.
// Unused opcodes yield zero.
module alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUControl,
  output logic [31:0] Result,
  output logic        Zero
);

  logic lt;

  assign lt = $signed(A) < $signed(B);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = A + B;
      ALU_SUB: Result = A - B;
      ALU_AND: Result = A & B;
      ALU_OR:  Result = A | B;
      ALU_SLT: Result = {31'b0, lt};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding, ALU, beq
// resolution and the EX/MEM pipeline register.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [4:0]  RD_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] PCPlus4M,
  output logic [31:0] WriteDataM,
  output logic [31:0] ALU_ResultM
);

  ex_mem_t     ex_mem_d;
  ex_mem_t     ex_mem_q;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] wdata;
  logic [31:0] alu_res;
  logic        zero;

  always_comb begin
    src_a = fwd_mux(ForwardAE, RD1_E,
                    ResultW, ex_mem_q.alu_result);
    wdata = fwd_mux(ForwardBE, RD2_E,
                    ResultW, ex_mem_q.alu_result);
    src_b = ALUSrcE ? Imm_Ext_E : wdata;
  end

  alu u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_res),
    .Zero       (zero)
  );

  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = RegWriteE;
    ex_mem_d.mem_write  = MemWriteE;
    ex_mem_d.result_src = ResultSrcE;
    ex_mem_d.rd         = RD_E;
    ex_mem_d.pc_plus4   = PCPlus4E;
    ex_mem_d.write_data = wdata;
    ex_mem_d.alu_result = alu_res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_mem_q <= '0;
    else      ex_mem_q <= ex_mem_d;
  end

  assign RegWriteM   = ex_mem_q.reg_write;
  assign MemWriteM   = ex_mem_q.mem_write;
  assign ResultSrcM  = ex_mem_q.result_src;
  assign RD_M        = ex_mem_q.rd;
  assign PCPlus4M    = ex_mem_q.pc_plus4;
  assign WriteDataM  = ex_mem_q.write_data;
  assign ALU_ResultM = ex_mem_q.alu_result;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a
// spec-level reference model checked every cycle.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE;
  logic        ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E;
  logic [4:0]  RD_E;
  logic [31:0] PCE, PCPlus4E, ResultW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int n_cmp;
  int n_bad;

  logic        e_rw, e_mw, e_rs;
  logic [4:0]  e_rd;
  logic [31:0] e_pc4, e_wd, e_alu;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return ($signed(a) < $signed(b))
                      ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(
    input logic [1:0] s,
    input logic [31:0] rf);
    if (s == 2'b01) return ResultW;
    if (s == 2'b10) return e_alu;
    return rf;
  endfunction

  function automatic logic [31:0] ref_res();
    logic [31:0] a, b;
    a = pick(ForwardAE, RD1_E);
    b = ALUSrcE ? Imm_Ext_E : pick(ForwardBE, RD2_E);
    return ref_alu(ALUControlE, a, b);
  endfunction

  // Reference EX/MEM contents
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_rw = 0; e_mw = 0; e_rs = 0; e_rd = 0;
      e_pc4 = 0; e_wd = 0; e_alu = 0;
    end else begin
      e_wd  = pick(ForwardBE, RD2_E);
      e_alu = ref_res();
      e_rw  = RegWriteE;
      e_mw  = MemWriteE;
      e_rs  = ResultSrcE;
      e_rd  = RD_E;
      e_pc4 = PCPlus4E;
    end
  end

  always @(negedge clk) begin
    check("PCSrcE", {31'b0, PCSrcE},
          {31'b0, BranchE && ref_res() == 0});
    check("PCTargetE", PCTargetE, PCE + Imm_Ext_E);
    check("RegWriteM", {31'b0, RegWriteM}, {31'b0, e_rw});
    check("MemWriteM", {31'b0, MemWriteM}, {31'b0, e_mw});
    check("ResultSrcM", {31'b0, ResultSrcM}, {31'b0, e_rs});
    check("RD_M", {27'b0, RD_M}, {27'b0, e_rd});
    check("PCPlus4M", PCPlus4M, e_pc4);
    check("WriteDataM", WriteDataM, e_wd);
    check("ALU_ResultM", ALU_ResultM, e_alu);
  end

  task automatic clr();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0;
    ResultSrcE = 0; BranchE = 0; ALUControlE = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
    PCE = 0; PCPlus4E = 0; ResultW = 0;
    ForwardAE = 0; ForwardBE = 0;
  endtask

  task automatic edge_m();
    @(posedge clk);
    #1;
  endtask

  task automatic m_zero(input string nm);
    check({nm, " rw"}, {31'b0, RegWriteM}, 0);
    check({nm, " mw"}, {31'b0, MemWriteM}, 0);
    check({nm, " rs"}, {31'b0, ResultSrcM}, 0);
    check({nm, " rd"}, {27'b0, RD_M}, 0);
    check({nm, " pc4"}, PCPlus4M, 0);
    check({nm, " wd"}, WriteDataM, 0);
    check({nm, " alu"}, ALU_ResultM, 0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    clr();
    #2;
    m_zero("rst0");
    @(posedge clk);
    #2 rst = 1'b1;

    // immediate add
    RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1;
    RD_E = 3; RegWriteE = 1;
    PCE = 32'h40; PCPlus4E = 32'h44;
    edge_m();
    check("addi res", ALU_ResultM, 32'd12);
    check("addi rd", {27'b0, RD_M}, 32'd3);
    check("addi rw", {31'b0, RegWriteM}, 32'd1);
    check("addi pc4", PCPlus4M, 32'h44);

    // forwarding chain
    clr();
    RD1_E = 4; RD2_E = 6; RegWriteE = 1; RD_E = 5;
    edge_m();
    check("fwd add", ALU_ResultM, 32'd10);
    clr();
    ForwardAE = 2'b10; RD1_E = 99; RD2_E = 4;
    ALUControlE = 3'b001;
    edge_m();
    check("fwd M sub", ALU_ResultM, 32'd6);
    clr();
    ForwardBE = 2'b01; ResultW = 20; RD1_E = 1;
    RD2_E = 77;
    edge_m();
    check("fwd W wd", WriteDataM, 32'd20);
    check("fwd W res", ALU_ResultM, 32'd21);
    clr();
    ForwardAE = 2'b11; ForwardBE = 2'b10;
    RD1_E = 3; RD2_E = 8; ALUControlE = 3'b011;
    edge_m();
    check("fwd 11/10 wd", WriteDataM, 32'd21);
    check("fwd 11/10 or", ALU_ResultM, 32'd23);

    // beq taken and not taken
    clr();
    BranchE = 1; ALUControlE = 3'b001;
    RD1_E = 8; RD2_E = 8; PCE = 32'h100;
    Imm_Ext_E = 32'hFFFF_FFF0;
    @(negedge clk);
    check("beq taken", {31'b0, PCSrcE}, 32'd1);
    check("beq tgt", PCTargetE, 32'h0000_00F0);
    edge_m();
    RD2_E = 9;
    @(negedge clk);
    check("beq not", {31'b0, PCSrcE}, 32'd0);
    edge_m();

    // slt and undefined opcode
    clr();
    ALUControlE = 3'b101;
    RD1_E = 32'h8000_0000; RD2_E = 1;
    edge_m();
    check("slt neg", ALU_ResultM, 32'd1);
    RD1_E = 1; RD2_E = 32'h8000_0000;
    edge_m();
    check("slt pos", ALU_ResultM, 32'd0);
    ALUControlE = 3'b111; RD1_E = 32'h55;
    RD2_E = 32'h0F;
    edge_m();
    check("op 111", ALU_ResultM, 32'd0);
    ALUControlE = 3'b010;
    edge_m();
    check("and", ALU_ResultM, 32'h05);

    // add wrap sets zero
    clr();
    BranchE = 1;
    RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    @(negedge clk);
    check("wrap zero", {31'b0, PCSrcE}, 32'd1);
    edge_m();
    check("wrap res", ALU_ResultM, 32'd0);

    // store
    clr();
    MemWriteE = 1; ALUSrcE = 1; ResultSrcE = 1;
    RD1_E = 32'h1000; Imm_Ext_E = 8;
    RD2_E = 32'hDEAD_BEEF;
    edge_m();
    check("st mw", {31'b0, MemWriteM}, 32'd1);
    check("st rs", {31'b0, ResultSrcM}, 32'd1);
    check("st wd", WriteDataM, 32'hDEAD_BEEF);
    check("st addr", ALU_ResultM, 32'h1008);

    // async reset mid-cycle
    clr();
    RegWriteE = 1; RD_E = 9; RD1_E = 1; RD2_E = 2;
    PCPlus4E = 32'h88;
    edge_m();
    check("pre rst", ALU_ResultM, 32'd3);
    #2 rst = 1'b0;
    #1;
    m_zero("rst async");
    edge_m();
    m_zero("rst hold");
    #1 rst = 1'b1;
    edge_m();
    check("post rst", ALU_ResultM, 32'd3);
    check("post rd", {27'b0, RD_M}, 32'd9);

    clr();
    edge_m();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
